// File: rtl/key_pkg.sv
// Shared constants and types for the key conditioner: default timing at a
// 50 MHz clock, the per-channel hold FSM state encoding and a small helper.
// Imported by key_channel and key_conditioner.
package key_pkg;

    // Default timing at 50 MHz
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;  // 20 ms
    localparam int DEF_LONG_CYCLES     = 25000000; // 0.5 s before first repeat
    localparam int DEF_REPEAT_CYCLES   = 5000000;  // 0.1 s between repeats

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LONG = 2'd1,
        REPEAT    = 2'd2
    } hold_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_channel.sv
// Purpose : one key channel: 2-flop sync, debounce, press/release edge pulses, auto-repeat.
// Latency : raw edge -> o_level / edge pulse after DEBOUNCE_CYCLES+2 cycles; repeat is combinational from FSM state.
// Backpr. : none; free-running, pulses are single-cycle and must be consumed when seen.
// Ports   : i_clk, i_rst_n (sync, active-low), i_key_n (raw, low = pressed),
//           o_level (debounced, high = pressed), o_press, o_release, o_repeat.
module key_channel
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_repeat
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HOLD_W = $clog2(max_int(LONG_CYCLES, REPEAT_CYCLES)) + 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);

    logic              r_sync1;
    logic              r_sync2;
    logic              r_stable;     // debounced raw polarity, 1 = released
    logic [DB_W-1:0]   r_db_cnt;
    logic              r_press;
    logic              r_release;
    hold_state_t       r_state;
    logic [HOLD_W-1:0] r_hold_cnt;

    logic              w_differ;
    logic              w_toggle;
    logic              w_level;
    hold_state_t       w_state_nxt;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic              w_repeat;

    assign w_differ = (r_sync2 != r_stable);
    // Accept the change only after DEBOUNCE_CYCLES consecutive differing samples.
    assign w_toggle = w_differ && (r_db_cnt == DB_LAST);
    assign w_level  = ~r_stable;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_stable  <= 1'b1;
            r_db_cnt  <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= i_key_n;
            r_sync2   <= r_sync1;
            // Pulses are registered alongside the stable-state toggle so they
            // coincide with the first cycle of the new level.
            r_press   <= w_toggle &&  r_stable;
            r_release <= w_toggle && !r_stable;
            if (w_toggle) begin
                r_stable <= ~r_stable;
                r_db_cnt <= '0;
            end else if (w_differ) begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_repeat    = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_press) begin
                    w_state_nxt = WAIT_LONG;
                    w_hold_nxt  = '0;
                end
            end
            WAIT_LONG: begin
                if (r_hold_cnt == LONG_LAST) begin
                    w_state_nxt = REPEAT;
                    w_hold_nxt  = '0;
                    w_repeat    = 1'b1;
                end else begin
                    w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end
            REPEAT: begin
                if (r_hold_cnt == REP_LAST) begin
                    w_hold_nxt = '0;
                    w_repeat   = 1'b1;
                end else begin
                    w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_hold_nxt  = '0;
            end
        endcase
        // Released level overrides everything; this also keeps repeat away
        // from the release cycle.
        if (!w_level) begin
            w_state_nxt = IDLE;
            w_hold_nxt  = '0;
            w_repeat    = 1'b0;
        end
    end

    assign o_level   = w_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_repeat  = w_repeat;

endmodule

// File: rtl/key_conditioner.sv
// Purpose : conditions N_KEYS raw board keys for the game core; key_level drives the core's left/right controls directly.
// Latency : raw edge -> key_level and press/release pulse after DEBOUNCE_CYCLES+2 cycles.
// Backpr. : none; all outputs are single-cycle pulses or levels, channels fully independent.
// Ports   : sys_clk, sys_rst_n (sync, active-low), key_n[N_KEYS] (raw, low = pressed),
//           key_level, key_press, key_release, key_repeat (all N_KEYS, high active).
module key_conditioner
    import key_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_repeat
);

    if (N_KEYS < 2 || DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_param
        $error("key_conditioner: all parameters must be >= 2");
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_ch (
            .i_clk     (sys_clk),
            .i_rst_n   (sys_rst_n),
            .i_key_n   (key_n[i]),
            .o_level   (key_level[i]),
            .o_press   (key_press[i]),
            .o_release (key_release[i]),
            .o_repeat  (key_repeat[i])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;

    localparam int NK   = 4;
    localparam int DEB  = 4;
    localparam int LONG = 10;
    localparam int REP  = 3;
    localparam int LAT  = DEB + 2;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n;
    logic [NK-1:0] key_n;
    logic [NK-1:0] key_level, key_press, key_release, key_repeat;

    key_conditioner #(
        .N_KEYS(NK), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .key_n       (key_n),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_repeat  (key_repeat)
    );

    always #5 sys_clk = ~sys_clk;

    // cyc == k during the cycle that follows posedge number k
    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    typedef struct {
        int          cyc;
        string       tag;
        logic [NK-1:0] lvl;
        logic [NK-1:0] pr;
        logic [NK-1:0] rl;
        logic [NK-1:0] rp;
    } exp_t;

    exp_t sb_q[$];

    // Per-scenario expected timeline, indexed by cycle relative to the stimulus start
    logic [NK-1:0] e_lvl [0:63];
    logic [NK-1:0] e_pr  [0:63];
    logic [NK-1:0] e_rl  [0:63];
    logic [NK-1:0] e_rp  [0:63];

    task automatic clear_exp();
        for (int k = 0; k < 64; k++) begin
            e_lvl[k] = '0; e_pr[k] = '0; e_rl[k] = '0; e_rp[k] = '0;
        end
    endtask

    // Accepted press at p, level held until r (exclusive), release pulse at r if rel.
    task automatic add_seg(input int ch, input int p, input int r, input bit rel);
        for (int t = p; t < r; t++) e_lvl[t][ch] = 1'b1;
        e_pr[p][ch] = 1'b1;
        if (rel) e_rl[r][ch] = 1'b1;
        for (int t = p + LONG; t < r; t += REP) e_rp[t][ch] = 1'b1;
    endtask

    task automatic commit(input string tag, input int base, input int len);
        exp_t e;
        for (int k = 0; k < len; k++) begin
            e.cyc = base + k; e.tag = tag;
            e.lvl = e_lvl[k]; e.pr = e_pr[k]; e.rl = e_rl[k]; e.rp = e_rp[k];
            sb_q.push_back(e);
        end
        clear_exp();
    endtask

    always @(negedge sys_clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            if (e.cyc < cyc) begin
                check_eq({e.tag, ".late"}, 32'(cyc), 32'(e.cyc));
            end else begin
                check_eq({e.tag, ".level"},   32'(key_level),   32'(e.lvl));
                check_eq({e.tag, ".press"},   32'(key_press),   32'(e.pr));
                check_eq({e.tag, ".release"}, 32'(key_release), 32'(e.rl));
                check_eq({e.tag, ".repeat"},  32'(key_repeat),  32'(e.rp));
            end
        end
    end

    function automatic logic [NK-1:0] stim(input int sid, input int r);
        logic [NK-1:0] k;
        k = '1;
        case (sid)
            1: if (r < 10) k[0] = 1'b0;                         // clean press, short hold
            2: if (r < 30) k[2] = 1'b0;                         // long hold with repeats
            3: if (r < 32 && (r % 4) != 3) k[1] = 1'b0;         // bounce 0,0,0,1
            4: if (r < DEB) k[1] = 1'b0;                        // low for exactly DEB cycles
            5: if (r < 8) begin k[0] = 1'b0; k[3] = 1'b0; end   // simultaneous keys
            6: if (r < 34) k[2] = 1'b0;                         // reset mid-hold
            default: k = '1;
        endcase
        return k;
    endfunction

    task automatic run(input int sid, input string tag, input int len);
        int base;
        base = cyc;
        commit(tag, base, len);
        for (int r = 0; r < len; r++) begin
            key_n     = stim(sid, r);
            sys_rst_n = !(sid == 6 && r == 12);
            @(posedge sys_clk); #1;
        end
        key_n = '1;
        sys_rst_n = 1'b1;
        for (int w = 0; w < 10 && sb_q.size() > 0; w++) begin
            @(posedge sys_clk); #1;
        end
        check_eq({tag, ".drain"}, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        clear_exp();
        sys_rst_n = 1'b0;
        key_n     = '1;
        // All outputs zero from the first reset edge on
        commit("reset", 1, 3);
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        run(0, "idle", 4);

        // Released at rel 10: release would land exactly where the first repeat
        // would have, so no repeat may appear.
        add_seg(0, LAT, 10 + LAT, 1'b1);
        run(1, "clean", 24);

        add_seg(2, LAT, 30 + LAT, 1'b1);
        run(2, "autorep", 44);

        run(3, "bounce", 40);

        add_seg(1, LAT, DEB + LAT, 1'b1);
        run(4, "minpulse", 16);

        add_seg(0, LAT, 8 + LAT, 1'b1);
        add_seg(3, LAT, 8 + LAT, 1'b1);
        run(5, "simul", 20);

        // Reset sampled at edge 13 aborts the hold with no release pulse;
        // the still-held key is re-accepted 6 cycles after reset is dropped.
        add_seg(2, LAT, 13, 1'b0);
        add_seg(2, 13 + LAT, 34 + LAT, 1'b1);
        run(6, "rst_hold", 48);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
